// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and the 32-bit sequencer built on it:
// opcodes, flag bit positions, sequencer op encoding and FSM states.
package alu_pkg;
   localparam int OPW = 8;
   localparam int FLW = 5;

   localparam logic [OPW-1:0] ALU_ADDCU = 8'b0000_0100;
   localparam logic [OPW-1:0] ALU_NOP   = 8'h00;

   localparam int FLG_Z = 4;
   localparam int FLG_C = 3;
   localparam int FLG_F = 2;
   localparam int FLG_L = 1;
   localparam int FLG_N = 0;

   typedef enum logic [1:0] {
      SEQ_ADD32  = 2'b00,
      SEQ_SUB32  = 2'b01,
      SEQ_CMP32U = 2'b10,
      SEQ_CMP32S = 2'b11
   } seq_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LO   = 2'b01,
      ST_HI   = 2'b10,
      ST_DONE = 2'b11
   } seq_state_e;
endpackage

// File: rtl/alu_seq32_flags.sv
// Combinational 32-bit flag former: merges the low-pass zero with the high-pass
// result/carry and operand signs into Z/C/F/L/N. Zero latency, no flow control.
module alu_seq32_flags
   import alu_pkg::*;
(
   input  logic           zero_lo,
   input  logic [15:0]    hi_c,
   input  logic           hi_carry,
   input  logic           a_sign,
   input  logic           beff_sign,
   input  logic [1:0]     op,
   output logic [FLW-1:0] flags
);
   logic r_sign;
   logic ovf;

   always_comb begin
      r_sign = hi_c[15];
      // Overflow is judged on the effective B, so sub/cmp reuse the add rule.
      ovf    = (~a_sign & ~beff_sign & r_sign) | (a_sign & beff_sign & ~r_sign);

      flags        = '0;
      flags[FLG_Z] = zero_lo & (hi_c == 16'h0000);
      flags[FLG_C] = hi_carry;
      flags[FLG_N] = r_sign;
      flags[FLG_F] = ovf;
      case (op)
         SEQ_CMP32U: flags[FLG_L] = ~hi_carry;
         SEQ_CMP32S: flags[FLG_L] = r_sign ^ ovf;
         default:    flags[FLG_L] = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_seq32.sv
// 32-bit add/sub/compare as two chained passes on a shared 16-bit ALU; 3 clocks accept->rsp_valid.
// Response held until rsp_ready; req_ready only in IDLE. ALU_SEQ32_PSR_EN adds a sticky psr flag register.
module alu_seq32
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [31:0]    req_a,
   input  logic [31:0]    req_b,
   output logic [15:0]    alu_a,
   output logic [15:0]    alu_b,
   output logic           alu_cin,
   output logic [OPW-1:0] alu_opcode,
   input  logic [15:0]    alu_c,
   input  logic [FLW-1:0] alu_flags,
`ifdef ALU_SEQ32_PSR_EN
   input  logic           psr_clr,
   output logic [FLW-1:0] psr,
`endif
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [31:0]    rsp_c,
   output logic [FLW-1:0] rsp_flags
);
   seq_state_e     state_q, state_d;
   seq_op_e        op_q, op_d;
   logic [31:0]    a_q, a_d;
   logic [31:0]    beff_q, beff_d;
   logic           carry_lo_q, carry_lo_d;
   logic           zero_lo_q, zero_lo_d;
   logic [15:0]    res_lo_q, res_lo_d;
   logic [31:0]    rsp_c_q, rsp_c_d;
   logic [FLW-1:0] rsp_flags_q, rsp_flags_d;
   logic [FLW-1:0] hi_flags;
   logic           flags_unused;

   assign flags_unused = ^alu_flags[FLG_F:FLG_N];

   alu_seq32_flags u_flags (
      .zero_lo   (zero_lo_q),
      .hi_c      (alu_c),
      .hi_carry  (alu_flags[FLG_C]),
      .a_sign    (a_q[31]),
      .beff_sign (beff_q[31]),
      .op        (op_q),
      .flags     (hi_flags)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      beff_d      = beff_q;
      carry_lo_d  = carry_lo_q;
      zero_lo_d   = zero_lo_q;
      res_lo_d    = res_lo_q;
      rsp_c_d     = rsp_c_q;
      rsp_flags_d = rsp_flags_q;
      alu_a       = 16'h0000;
      alu_b       = 16'h0000;
      alu_cin     = 1'b0;
      alu_opcode  = ALU_NOP;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = seq_op_e'(req_op);
               a_d     = req_a;
               beff_d  = (seq_op_e'(req_op) == SEQ_ADD32) ? req_b : ~req_b;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            // Subtract as A + ~B + 1: the +1 enters through the low carry-in.
            alu_opcode = ALU_ADDCU;
            alu_a      = a_q[15:0];
            alu_b      = beff_q[15:0];
            alu_cin    = (op_q != SEQ_ADD32);
            carry_lo_d = alu_flags[FLG_C];
            zero_lo_d  = alu_flags[FLG_Z];
            res_lo_d   = alu_c;
            state_d    = ST_HI;
         end
         ST_HI: begin
            alu_opcode  = ALU_ADDCU;
            alu_a       = a_q[31:16];
            alu_b       = beff_q[31:16];
            alu_cin     = carry_lo_q;
            rsp_c_d     = (op_q[1]) ? 32'h0000_0000 : {alu_c, res_lo_q};
            rsp_flags_d = hi_flags;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= SEQ_ADD32;
         a_q         <= '0;
         beff_q      <= '0;
         carry_lo_q  <= 1'b0;
         zero_lo_q   <= 1'b0;
         res_lo_q    <= '0;
         rsp_c_q     <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         beff_q      <= beff_d;
         carry_lo_q  <= carry_lo_d;
         zero_lo_q   <= zero_lo_d;
         res_lo_q    <= res_lo_d;
         rsp_c_q     <= rsp_c_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign rsp_c     = rsp_c_q;
   assign rsp_flags = rsp_flags_q;

`ifdef ALU_SEQ32_PSR_EN
   logic [FLW-1:0] psr_q, psr_d;

   always_comb begin
      psr_d = psr_q;
      if (psr_clr)                     psr_d = '0;
      else if (rsp_valid && rsp_ready) psr_d = rsp_flags_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) psr_q <= '0;
      else       psr_q <= psr_d;
   end

   assign psr = psr_q;
`endif
endmodule

// File: tb/tb_alu_seq32.sv
// Directed bench for alu_seq32 with a behavioural 16-bit ALU attached to the alu_* ports.
module tb_alu_seq32;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [15:0] alu_a, alu_b;
   logic        alu_cin;
   logic [7:0]  alu_opcode;
   logic [15:0] alu_c;
   logic [4:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_c;
   logic [4:0]  rsp_flags;
`ifdef ALU_SEQ32_PSR_EN
   logic        psr_clr;
   logic [4:0]  psr;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   alu_seq32 dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_opcode (alu_opcode),
      .alu_c      (alu_c),
      .alu_flags  (alu_flags),
`ifdef ALU_SEQ32_PSR_EN
      .psr_clr    (psr_clr),
      .psr        (psr),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_c      (rsp_c),
      .rsp_flags  (rsp_flags)
   );

   // Behavioural 16-bit ALU: only ADDCU is modelled, everything else yields zero.
   logic [16:0] sum;
   always_comb begin
      sum       = '0;
      alu_c     = '0;
      alu_flags = '0;
      if (alu_opcode == 8'h04) begin
         sum          = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin};
         alu_c        = sum[15:0];
         alu_flags[4] = (sum[15:0] == 16'h0000);
         alu_flags[3] = sum[16];
         alu_flags[2] = (~alu_a[15] & ~alu_b[15] & sum[15]) | (alu_a[15] & alu_b[15] & ~sum[15]);
         alu_flags[0] = sum[15];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issue one request with rsp_ready low, check latency and response, then hand it off.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_c, input logic [4:0] exp_f);
      int lat;
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 32'd3);
      chk({tag, "_rsp_c"}, rsp_c, exp_c);
      chk({tag, "_rsp_flags"}, {27'b0, rsp_flags}, {27'b0, exp_f});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, "_released"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] held_c;
      logic [4:0]  held_f;
      int          stable_bad;

      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
`ifdef ALU_SEQ32_PSR_EN
      psr_clr = 1'b0;
`endif
      #12;
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_c", rsp_c, 32'd0);
      chk("reset_rsp_flags", {27'b0, rsp_flags}, 32'd0);
      chk("reset_alu_opcode", {24'b0, alu_opcode}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Flags are {Z,C,F,L,N}.
      run_op("add_carry_lo", 2'b00, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 5'b00000);
`ifdef ALU_SEQ32_PSR_EN
      chk("psr_after_add", {27'b0, psr}, 32'd0);
`endif
      run_op("sub_borrow", 2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'b00001);
`ifdef ALU_SEQ32_PSR_EN
      chk("psr_after_sub", {27'b0, psr}, 32'h01);
`endif
      run_op("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b00101);
      run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b11000);
      run_op("cmps_lt", 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01011);
      run_op("cmpu_gt", 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01001);
      run_op("cmpu_eq", 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 5'b11000);

      // Backpressure: response held 5 clocks while another request waits.
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'h0000_0003; req_b = 32'h0000_0004;
      @(posedge clk); #1;
      req_a = 32'hDEAD_BEEF; req_b = 32'h1111_1111;
      repeat (2) begin @(posedge clk); #1; end
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_c", rsp_c, 32'h0000_0007);
      held_c = rsp_c; held_f = rsp_flags; stable_bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rsp_c !== held_c || rsp_flags !== held_f || rsp_valid !== 1'b1 || req_ready !== 1'b0)
            stable_bad++;
      end
      chk("bp_stable_5clk", stable_bad, 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'b0, rsp_valid}, 32'd0);

      // Reset during the high pass aborts the operation.
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'h0001_0001; req_b = 32'h0001_0001;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("hi_opcode", {24'b0, alu_opcode}, 32'h04);
      chk("hi_alu_a", {16'b0, alu_a}, 32'h0001);
      reset = 1'b1; #1;
      chk("abort_opcode", {24'b0, alu_opcode}, 32'd0);
      chk("abort_alu_a", {16'b0, alu_a}, 32'd0);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort_rsp_c", rsp_c, 32'd0);
      chk("abort_rsp_flags", {27'b0, rsp_flags}, 32'd0);
      #3; reset = 1'b0;
      stable_bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) stable_bad++;
      end
      chk("abort_no_rsp", stable_bad, 32'd0);
      run_op("after_abort", 2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0002, 5'b00000);

`ifdef ALU_SEQ32_PSR_EN
      run_op("psr_load", 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 5'b11000);
      chk("psr_loaded", {27'b0, psr}, 32'h18);
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'h0; req_b = 32'h1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rsp_ready = 1'b1; psr_clr = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0; psr_clr = 1'b0;
      chk("psr_clr_wins", {27'b0, psr}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
